// File: rtl/reg_file_8x8.sv
// reg_file_8x8 -- eight-entry, DATA_W-bit register file with per-entry valid
// flags and a saturating write counter. Operand source / result sink for the
// single-cycle ALU.
//
// Ports:
//   CLK          clock, all state updates on the rising edge
//   RESET_N      asynchronous active-low reset (clears data, valid, count)
//   IN           write data (ALU result)
//   INADDRESS    write address
//   WRITE        write enable, sampled on the rising edge
//   OUT1ADDRESS  read address, port 1 (operand A)
//   OUT2ADDRESS  read address, port 2 (operand B)
//   OUT1/OUT2    combinational read data
//   OUT1VALID/OUT2VALID  addressed entry written since reset
//   WRCOUNT      accepted writes since reset, saturating at 255
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a read of the address being written in
//                      the current cycle returns IN (and valid = 1) before
//                      the edge. Undefined: reads show stored state only.

module reg_file_8x8 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    output logic              OUT1VALID,
    output logic              OUT2VALID,
    output logic [7:0]        WRCOUNT
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             vld;
    logic [7:0]                   wrcount;

    // X/Z on WRITE evaluates false here, so it never commits a write.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            regs    <= '0;
            vld     <= '0;
            wrcount <= '0;
        end else if (WRITE) begin
            regs[INADDRESS] <= IN;
            vld[INADDRESS]  <= 1'b1;
            if (wrcount != 8'hFF)
                wrcount <= wrcount + 8'd1;
        end
    end

    assign WRCOUNT = wrcount;

    always_comb begin
        OUT1      = regs[OUT1ADDRESS];
        OUT1VALID = vld[OUT1ADDRESS];
        OUT2      = regs[OUT2ADDRESS];
        OUT2VALID = vld[OUT2ADDRESS];
`ifdef REGFILE_BYPASS_EN
        // Forward pending write data; suppressed under reset so outputs
        // read as zero while RESET_N is held.
        if (RESET_N && WRITE && (OUT1ADDRESS == INADDRESS)) begin
            OUT1      = IN;
            OUT1VALID = 1'b1;
        end
        if (RESET_N && WRITE && (OUT2ADDRESS == INADDRESS)) begin
            OUT2      = IN;
            OUT2VALID = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_8x8.sv
// Directed self-checking bench for reg_file_8x8. Inputs change on the falling
// edge; outputs are sampled 1 time unit after an input change or rising edge.

module tb_reg_file_8x8;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [7:0] IN;
    logic [2:0] INADDRESS;
    logic       WRITE;
    logic [2:0] OUT1ADDRESS;
    logic [2:0] OUT2ADDRESS;
    logic [7:0] OUT1;
    logic [7:0] OUT2;
    logic       OUT1VALID;
    logic       OUT2VALID;
    logic [7:0] WRCOUNT;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    reg_file_8x8 #(.DATA_W(8), .ADDR_W(3)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .IN(IN), .INADDRESS(INADDRESS),
        .WRITE(WRITE), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .OUT1(OUT1), .OUT2(OUT2), .OUT1VALID(OUT1VALID), .OUT2VALID(OUT2VALID),
        .WRCOUNT(WRCOUNT)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One write, committed on the next rising edge; WRITE dropped after it.
    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge CLK);
        WRITE = 1'b1; IN = d; INADDRESS = a;
        @(negedge CLK);
        WRITE = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0; WRITE = 1'b0; IN = '0; INADDRESS = '0;
        OUT1ADDRESS = '0; OUT2ADDRESS = '0;

        // Reset held: every entry reads zero and invalid.
        for (int a = 0; a < 8; a++) begin
            OUT1ADDRESS = 3'(a); OUT2ADDRESS = 3'(7 - a);
            #1;
            chk("rst_out1", OUT1, 0);
            chk("rst_v1", OUT1VALID, 0);
            chk("rst_out2", OUT2, 0);
            chk("rst_v2", OUT2VALID, 0);
        end
        chk("rst_cnt", WRCOUNT, 0);

        @(negedge CLK); RESET_N = 1'b1;

        // Write/read-back: r3 = -44, r5 = 10.
        wr(3'd3, 8'hD4);
        wr(3'd5, 8'h0A);
        OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd5; #1;
        chk("rb_out1", OUT1, 8'hD4);
        chk("rb_out2", OUT2, 8'h0A);
        chk("rb_v1", OUT1VALID, 1);
        chk("rb_v2", OUT2VALID, 1);
        chk("rb_cnt", WRCOUNT, 2);
        OUT1ADDRESS = 3'd0; #1;
        chk("unwritten_v", OUT1VALID, 0);

        // Same-address read during write (count 3 after r2=15, 4 after r2=11).
        wr(3'd2, 8'd15);
        @(negedge CLK);
        WRITE = 1'b1; IN = 8'd11; INADDRESS = 3'd2; OUT1ADDRESS = 3'd2; #1;
`ifdef REGFILE_BYPASS_EN
        chk("raw_pre", OUT1, 8'd11);
`else
        chk("raw_pre", OUT1, 8'd15);
`endif
        @(posedge CLK); #1;
        chk("raw_post", OUT1, 8'd11);
        chk("raw_cnt", WRCOUNT, 4);
        @(negedge CLK); WRITE = 1'b0;

        // Valid flag before the first write to r7 (count 5 after).
        WRITE = 1'b1; IN = 8'h77; INADDRESS = 3'd7; OUT2ADDRESS = 3'd7; #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_v_pre", OUT2VALID, 1);
        chk("byp_d_pre", OUT2, 8'h77);
`else
        chk("byp_v_pre", OUT2VALID, 0);
        chk("byp_d_pre", OUT2, 8'h00);
`endif
        @(posedge CLK); #1;
        chk("r7_post_v", OUT2VALID, 1);
        chk("r7_post_d", OUT2, 8'h77);
        @(negedge CLK); WRITE = 1'b0;

        // WRITE = 0 hold over five edges.
        IN = 8'd99; INADDRESS = 3'd3;
        repeat (5) @(posedge CLK);
        #1;
        OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd3; #1;
        chk("hold_r3", OUT1, 8'hD4);
        chk("hold_cnt", WRCOUNT, 5);
        chk("same_port2", OUT2, 8'hD4);

        // Reset asserted on the edge of a pending write: write is lost and
        // everything clears immediately.
        @(negedge CLK);
        WRITE = 1'b1; IN = 8'h55; INADDRESS = 3'd3;
        @(posedge CLK); RESET_N = 1'b0;
        #1; WRITE = 1'b0; #1;
        chk("arst_out1", OUT1, 0);
        chk("arst_v1", OUT1VALID, 0);
        chk("arst_cnt", WRCOUNT, 0);

        // Mid-cycle reset after writes.
        @(negedge CLK); RESET_N = 1'b1;
        wr(3'd3, 8'h21);
        #1; chk("mid_pre", OUT1, 8'h21);
        #2; RESET_N = 1'b0; #1;
        chk("mid_out1", OUT1, 0);
        chk("mid_cnt", WRCOUNT, 0);

        // Saturation: 300 writes, data = i, address = i mod 8.
        @(negedge CLK); RESET_N = 1'b1;
        for (int i = 0; i < 300; i++) begin
            wr(3'(i % 8), 8'(i));
            if (i == 253) chk("cnt_254", WRCOUNT, 254);
            if (i == 254) chk("cnt_255", WRCOUNT, 255);
            if (i == 255) chk("cnt_sat", WRCOUNT, 255);
        end
        OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd0; #1;
        chk("sat_cnt", WRCOUNT, 255);
        chk("last_r3", OUT1, 8'h2B);   // i = 299 -> 0x12B truncated
        chk("last_r0", OUT2, 8'h28);   // i = 296 -> 0x128 truncated
        @(negedge CLK); RESET_N = 1'b0; #1;
        chk("sat_rst_cnt", WRCOUNT, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
